// File: rtl/pong_pkg.sv
// Shared pong definitions: game states and playfield geometry.
// Used by the game controller and the pixel generator.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_MISS  = 2'd3
  } game_state_e;

  localparam logic [9:0] H_MAX     = 10'd640;
  localparam logic [9:0] V_MAX     = 10'd480;
  localparam logic [9:0] WALL_X_R  = 10'd35;
  localparam logic [9:0] PAD_X_L   = 10'd600;
  localparam logic [9:0] PAD_X_R   = 10'd603;
  localparam logic [9:0] PAD_H     = 10'd72;
  localparam logic [9:0] PAD_V     = 10'd4;
  localparam logic [9:0] BALL_SIZE = 10'd8;
  localparam logic [9:0] BALL_V    = 10'd2;

  localparam int unsigned SERVE_FRAMES = 60;
  localparam logic [1:0]  LIVES        = 2'd3;

  localparam logic [9:0] PAD_Y_MAX   = V_MAX - PAD_H;
  localparam logic [9:0] PAD_Y_INIT  = (V_MAX - PAD_H) / 10'd2;
  localparam logic [9:0] BALL_X_INIT = (H_MAX - BALL_SIZE) / 10'd2;
  localparam logic [9:0] BALL_Y_INIT = (V_MAX - BALL_SIZE) / 10'd2;

  // Widen to 11 bits so sums used in compares never wrap.
  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control inputs and game-state outputs of the pong controller.
interface pong_game_ctrl_if;
  logic       enable;
  logic       up;
  logic       down;
  logic       frame_tick;
  logic [9:0] pad_y_t;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_on;
  logic       miss;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] game_state;

  modport master (
    output enable, up, down, frame_tick,
    input  pad_y_t, ball_x, ball_y, ball_on, miss, score, lives, game_state
  );

  modport slave (
    input  enable, up, down, frame_tick,
    output pad_y_t, ball_x, ball_y, ball_on, miss, score, lives, game_state
  );
endinterface

// File: rtl/pong_ball_mover.sv
// Combinational ball collision detect and next position/direction.
// dir_x/dir_y: 1 = moving +x/+y, 0 = moving -x/-y.
module pong_ball_mover
  import pong_pkg::*;
(
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] pad_y_t,
  input  logic       dir_x,
  input  logic       dir_y,
  output logic       hit,
  output logic       missed,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       next_dir_x,
  output logic       next_dir_y
);

  logic [10:0] bx, by, py, bx_r, by_b;
  logic        at_top, at_bottom, at_wall, pad_x_ok, pad_y_ok;

  assign bx   = ext11(ball_x);
  assign by   = ext11(ball_y);
  assign py   = ext11(pad_y_t);
  assign bx_r = bx + ext11(BALL_SIZE) - 11'd1;
  assign by_b = by + ext11(BALL_SIZE) - 11'd1;

  assign at_top    = by <= ext11(BALL_V);
  assign at_bottom = by + ext11(BALL_SIZE) >= ext11(V_MAX - BALL_V);
  assign at_wall   = bx <= ext11(WALL_X_R);
  assign pad_x_ok  = (bx_r >= ext11(PAD_X_L)) && (bx_r <= ext11(PAD_X_R));
  assign pad_y_ok  = (by_b >= py) && (by <= py + ext11(PAD_H) - 11'd1);

  assign hit    = dir_x && pad_x_ok && pad_y_ok;
  assign missed = bx >= ext11(H_MAX - BALL_SIZE - BALL_V);

  always_comb begin
    next_dir_y = dir_y;
    if (at_top)
      next_dir_y = 1'b1;
    else if (at_bottom)
      next_dir_y = 1'b0;

    next_dir_x = dir_x;
    if (at_wall)
      next_dir_x = 1'b1;
    else if (hit)
      next_dir_x = 1'b0;

    next_x = next_dir_x ? ball_x + BALL_V : ball_x - BALL_V;
    next_y = next_dir_y ? ball_y + BALL_V : ball_y - BALL_V;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong controller: paddle, ball sequencing, score and lives.
//   state | meaning
//   IDLE  | no game; ball hidden, waiting for up/down to start
//   SERVE | ball held at centre for SERVE_FRAMES ticks
//   PLAY  | ball moving, collisions resolved each tick
//   MISS  | ball lost; next tick serves again or ends the game
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);

  game_state_e state, state_d;
  logic [9:0]  pad, pad_d, pad_next, bx, bx_d, by, by_d;
  logic        dir_x, dir_x_d, dir_y, dir_y_d, miss_q, miss_d;
  logic [7:0]  score, score_d;
  logic [1:0]  lives, lives_d;
  logic [5:0]  cnt, cnt_d;
  logic        tick, hit, missed, ndx, ndy;
  logic [9:0]  nx, ny;

  assign tick = bus.frame_tick & bus.enable;

  pong_ball_mover u_mover (
    .ball_x     (bx),
    .ball_y     (by),
    .pad_y_t    (pad),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .hit        (hit),
    .missed     (missed),
    .next_x     (nx),
    .next_y     (ny),
    .next_dir_x (ndx),
    .next_dir_y (ndy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pad    <= PAD_Y_INIT;
      bx     <= BALL_X_INIT;
      by     <= BALL_Y_INIT;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      miss_q <= 1'b0;
      score  <= 8'd0;
      lives  <= LIVES;
      cnt    <= 6'd0;
    end else begin
      state  <= state_d;
      pad    <= pad_d;
      bx     <= bx_d;
      by     <= by_d;
      dir_x  <= dir_x_d;
      dir_y  <= dir_y_d;
      miss_q <= miss_d;
      score  <= score_d;
      lives  <= lives_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    pad_next = pad;
    if (bus.up && !bus.down)
      pad_next = (pad < PAD_V) ? 10'd0 : pad - PAD_V;
    else if (bus.down && !bus.up)
      pad_next = (ext11(pad) + ext11(PAD_V) > ext11(PAD_Y_MAX)) ? PAD_Y_MAX : pad + PAD_V;
  end

  always_comb begin
    state_d = state;
    pad_d   = pad;
    bx_d    = bx;
    by_d    = by;
    dir_x_d = dir_x;
    dir_y_d = dir_y;
    miss_d  = 1'b0;
    score_d = score;
    lives_d = lives;
    cnt_d   = cnt;
    if (tick) begin
      if (state == ST_SERVE || state == ST_PLAY)
        pad_d = pad_next;
      case (state)
        ST_IDLE: begin
          if (bus.up || bus.down) begin
            state_d = ST_SERVE;
            score_d = 8'd0;
            lives_d = LIVES;
            bx_d    = BALL_X_INIT;
            by_d    = BALL_Y_INIT;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
            cnt_d   = 6'd0;
          end
        end
        ST_SERVE: begin
          if (cnt == SERVE_LAST)
            state_d = ST_PLAY;
          else
            cnt_d = cnt + 6'd1;
        end
        ST_PLAY: begin
          // A miss freezes the ball where it left the field.
          if (missed) begin
            miss_d  = 1'b1;
            lives_d = lives - 2'd1;
            state_d = ST_MISS;
          end else begin
            bx_d    = nx;
            by_d    = ny;
            dir_x_d = ndx;
            dir_y_d = ndy;
            if (hit && score != 8'hFF)
              score_d = score + 8'd1;
          end
        end
        ST_MISS: begin
          state_d = (lives == 2'd0) ? ST_IDLE : ST_SERVE;
          bx_d    = BALL_X_INIT;
          by_d    = BALL_Y_INIT;
          dir_x_d = 1'b1;
          dir_y_d = 1'b1;
          cnt_d   = 6'd0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.game_state = state;
    bus.ball_on    = (state == ST_SERVE) || (state == ST_PLAY);
    bus.pad_y_t    = pad;
    bus.ball_x     = bx;
    bus.ball_y     = by;
    bus.miss       = miss_q;
    bus.score      = score;
    bus.lives      = lives;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: game-rule model plus directed and random frames.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus ();
  pong_game_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  int miss_seen = 0;
  bit chk_on = 1'b0;

  // Game model: positions as plain integers, velocity as +1/-1 per axis.
  int m_state, m_pad, m_bx, m_by, m_vx, m_vy, m_score, m_lives, m_frames;
  bit m_miss;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_centre();
    m_bx = 316; m_by = 236; m_vx = 1; m_vy = 1;
  endtask

  task automatic m_paddle();
    if (bus.up && !bus.down) m_pad = (m_pad - 4 < 0) ? 0 : m_pad - 4;
    else if (bus.down && !bus.up) m_pad = (m_pad + 4 > 408) ? 408 : m_pad + 4;
  endtask

  task automatic model_step();
    int old_pad;
    if (reset) begin
      m_state = 0; m_pad = 204; m_centre(); m_score = 0; m_lives = 3;
      m_frames = 0; m_miss = 0;
      return;
    end
    m_miss = 0;
    if (!(bus.frame_tick && bus.enable)) return;
    old_pad = m_pad;
    if (m_state == 1 || m_state == 2) m_paddle();
    case (m_state)
      0: if (bus.up || bus.down) begin
           m_state = 1; m_score = 0; m_lives = 3; m_centre(); m_frames = 0;
         end
      1: begin
           m_frames++;
           if (m_frames == 60) m_state = 2;
         end
      2: begin
           if (m_bx >= 630) begin
             m_miss = 1; m_lives--; m_state = 3;
           end else begin
             if (m_by <= 2) m_vy = 1;
             else if (m_by + 8 >= 478) m_vy = -1;
             if (m_bx <= 35) m_vx = 1;
             else if (m_vx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                      m_by + 7 >= old_pad && m_by <= old_pad + 71) begin
               m_vx = -1;
               if (m_score < 255) m_score++;
             end
             m_bx += 2 * m_vx;
             m_by += 2 * m_vy;
           end
         end
      default: begin
           m_centre(); m_frames = 0;
           m_state = (m_lives == 0) ? 0 : 1;
         end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("state",   int'(bus.game_state), m_state);
      chk("pad_y_t", int'(bus.pad_y_t),    m_pad);
      chk("ball_x",  int'(bus.ball_x),     m_bx);
      chk("ball_y",  int'(bus.ball_y),     m_by);
      chk("ball_on", int'(bus.ball_on),    (m_state == 1 || m_state == 2) ? 1 : 0);
      chk("miss",    int'(bus.miss),       int'(m_miss));
      chk("score",   int'(bus.score),      m_score);
      chk("lives",   int'(bus.lives),      m_lives);
      if (bus.miss) miss_seen++;
    end
  end

  task automatic tick(input int gap);
    bus.frame_tick = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ms0, k, sx, sy, sp, ss, st;
    reset = 1'b1; bus.enable = 1'b1; bus.up = 1'b0; bus.down = 1'b0; bus.frame_tick = 1'b0;
    @(posedge clk); #1 chk_on = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    repeat (5) tick(2);
    chk("idle_state", int'(bus.game_state), 0);
    chk("idle_pad",   int'(bus.pad_y_t), 204);
    chk("idle_bx",    int'(bus.ball_x), 316);
    chk("idle_by",    int'(bus.ball_y), 236);
    chk("idle_on",    int'(bus.ball_on), 0);
    chk("idle_lives", int'(bus.lives), 3);

    bus.down = 1'b1; tick(2);
    chk("serve_state", int'(bus.game_state), 1);
    chk("serve_on",    int'(bus.ball_on), 1);
    chk("serve_pad",   int'(bus.pad_y_t), 204);

    repeat (60) tick(1);
    chk("play_state", int'(bus.game_state), 2);
    chk("pad_bottom", int'(bus.pad_y_t), 408);
    chk("play_bx0",   int'(bus.ball_x), 316);

    bus.down = 1'b0; bus.up = 1'b1; tick(1);
    chk("first_move_x", int'(bus.ball_x), 318);
    chk("first_move_y", int'(bus.ball_y), 238);
    chk("pad_up_step",  int'(bus.pad_y_t), 404);

    bus.down = 1'b1; repeat (5) tick(1);
    chk("pad_both_hold", int'(bus.pad_y_t), 404);
    bus.down = 1'b0; repeat (105) tick(1);
    chk("pad_top",  int'(bus.pad_y_t), 0);
    chk("run_bx",   int'(bus.ball_x), 538);
    chk("run_by",   int'(bus.ball_y), 458);
    bus.up = 1'b0;

    repeat (6) tick(1);
    chk("bottom_y", int'(bus.ball_y), 470);
    tick(1);
    chk("bounce_y", int'(bus.ball_y), 468);

    ms0 = miss_seen; k = 0;
    while (miss_seen == ms0 && k < 200) begin tick(1); k++; end
    chk("miss_pulses", miss_seen - ms0, 1);
    chk("miss_state",  int'(bus.game_state), 3);
    chk("miss_lives",  int'(bus.lives), 2);
    chk("miss_bx",     int'(bus.ball_x), 630);
    tick(1);
    chk("reserve_state", int'(bus.game_state), 1);
    chk("reserve_bx",    int'(bus.ball_x), 316);
    chk("reserve_by",    int'(bus.ball_y), 236);

    bus.down = 1'b1; k = 0;
    while (bus.score == 8'd0 && k < 300) begin tick(1); k++; end
    chk("hit_score", int'(bus.score), 1);
    chk("hit_bx",    int'(bus.ball_x), 592);
    chk("hit_pad",   int'(bus.pad_y_t), 408);

    sx = int'(bus.ball_x); sy = int'(bus.ball_y); sp = int'(bus.pad_y_t);
    ss = int'(bus.score); st = int'(bus.game_state);
    bus.enable = 1'b0; bus.down = 1'b0; bus.up = 1'b1;
    repeat (20) tick(1);
    chk("frz_bx",    int'(bus.ball_x), sx);
    chk("frz_by",    int'(bus.ball_y), sy);
    chk("frz_pad",   int'(bus.pad_y_t), sp);
    chk("frz_score", int'(bus.score), ss);
    chk("frz_state", int'(bus.game_state), st);
    bus.enable = 1'b1; bus.up = 1'b0;

    bus.frame_tick = 1'b1; reset = 1'b1;
    @(posedge clk); #1 bus.frame_tick = 1'b0; reset = 1'b0;
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_pad",   int'(bus.pad_y_t), 204);
    chk("rst_bx",    int'(bus.ball_x), 316);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_lives", int'(bus.lives), 3);

    bus.up = 1'b1; tick(1); bus.up = 1'b0;
    ms0 = miss_seen; k = 0;
    while (bus.game_state != 2'd0 && k < 1500) begin tick(1); k++; end
    chk("over_misses", miss_seen - ms0, 3);
    chk("over_state",  int'(bus.game_state), 0);
    chk("over_lives",  int'(bus.lives), 0);

    for (int i = 0; i < 600; i++) begin
      bus.up     = 1'($urandom_range(0, 1));
      bus.down   = 1'($urandom_range(0, 1));
      bus.enable = ($urandom_range(0, 9) != 0);
      tick($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
